// File: rtl/fifo_word_packer_pkg.sv
// Shared types for the word packer: the output-slot state encoding.
package fifo_word_packer_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_e;

endpackage

// File: rtl/FIFOInterface.sv
// Valid/ready/data stream bundle; "in" is the sink view, "out" the source view.
interface FIFOInterface #(
    parameter int W = 8
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport in  (input valid, input data, output ready);
    modport out (output valid, output data, input ready);
endinterface

// File: rtl/fifo_word_packer.sv
// Packs K consecutive Nb-bit stream words into one Nb*K-bit word, first word in
// the LSBs; a flush emits a partially filled group with zeroed upper lanes.
module fifo_word_packer
    import fifo_word_packer_pkg::*;
#(
    parameter int Nb = 8,
    parameter int K  = 3,
    parameter int Mk = $clog2(K) + 1
) (
    input  logic          clk,
    input  logic          reset,
    FIFOInterface.in      in,
    FIFOInterface.out     out,
    input  logic          flush,
    output logic [Mk-1:0] fill,
    output logic          out_partial
);

    pack_state_e         state_q, state_d;
    logic [Nb-1:0]       lanes_q [K-1];
    logic [Nb-1:0]       lanes_d [K-1];
    logic [Mk-1:0]       fill_q, fill_d;
    logic [Nb*K-1:0]     data_q, data_d;
    logic                partial_q, partial_d;

    logic                slot_free;
    logic                in_fire;
    logic                complete;
    logic                flush_go;
    logic                emit;
    logic [Nb*K-1:0]     held_word;
    logic [Nb*K-1:0]     emit_word;

    assign slot_free = (state_q == FILL) || out.ready;
    assign in.ready  = slot_free;
    assign in_fire   = in.valid && slot_free;
    assign complete  = in_fire && (fill_q == Mk'(K - 1));
    // A flush only counts if something is held or arriving, and never splits a completing group.
    assign flush_go  = flush && slot_free && !complete && ((fill_q != '0) || in_fire);
    assign emit      = complete || flush_go;

    // Lanes above the fill point are always zero, so OR-ing the incoming word is enough.
    for (genvar gi = 0; gi < K; gi++) begin : g_lane
        if (gi < K - 1) begin : g_held
            assign held_word[gi*Nb +: Nb] = lanes_q[gi];
        end else begin : g_top
            assign held_word[gi*Nb +: Nb] = '0;
        end
        assign emit_word[gi*Nb +: Nb] = held_word[gi*Nb +: Nb]
                                      | ((in_fire && (fill_q == Mk'(gi))) ? in.data : '0);
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        partial_d = partial_q;
        fill_d    = fill_q;
        lanes_d   = lanes_q;
        if (emit) begin
            state_d   = HOLD;
            data_d    = emit_word;
            partial_d = flush_go;
            fill_d    = '0;
            for (int i = 0; i < K - 1; i++) begin
                lanes_d[i] = '0;
            end
        end else begin
            if (in_fire) begin
                for (int i = 0; i < K - 1; i++) begin
                    if (fill_q == Mk'(i)) begin
                        lanes_d[i] = in.data;
                    end
                end
                fill_d = fill_q + Mk'(1);
            end
            if ((state_q == HOLD) && out.ready) begin
                state_d = FILL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= FILL;
            data_q    <= '0;
            partial_q <= 1'b0;
            fill_q    <= '0;
            for (int i = 0; i < K - 1; i++) begin
                lanes_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            partial_q <= partial_d;
            fill_q    <= fill_d;
            lanes_q   <= lanes_d;
        end
    end

    assign out.valid   = (state_q == HOLD);
    assign out.data    = data_q;
    assign fill        = fill_q;
    assign out_partial = partial_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench for fifo_word_packer with Nb=8, K=3.
module tb_fifo_word_packer;

    typedef struct {
        logic [23:0] data;
        logic        partial;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [2:0] fill;
    logic       out_partial;

    FIFOInterface #(.W(8))  in_if ();
    FIFOInterface #(.W(24)) out_if ();

    fifo_word_packer #(.Nb(8), .K(3), .Mk(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in_if),
        .out         (out_if),
        .flush       (flush),
        .fill        (fill),
        .out_partial (out_partial)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    exp_t        sb[$];
    logic        rdy_s;
    logic [23:0] odata_s;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_word(input logic [23:0] d, input logic p);
        exp_t e;
        e.data    = d;
        e.partial = p;
        sb.push_back(e);
    endtask

    // One cycle: drive at posedge+1, sample at negedge, return at next posedge+1.
    task automatic step(input logic v, input logic [7:0] d, input logic fl, input logic rdy);
        in_if.valid  = v;
        in_if.data   = d;
        flush        = fl;
        out_if.ready = rdy;
        @(negedge clk);
        rdy_s   = in_if.ready;
        odata_s = out_if.data;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    always @(negedge clk) begin
        if (reset && out_if.valid && out_if.ready) begin
            $display("[TB] out 0x%06h partial %0d", out_if.data, out_partial);
            if (sb.size() == 0) begin
                check_eq("sb_extra", 32'(out_if.valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("out_data", 32'(out_if.data), 32'(e.data));
                check_eq("out_partial", 32'(out_partial), 32'(e.partial));
            end
        end
    end

    initial begin
        reset        = 1'b0;
        flush        = 1'b0;
        in_if.valid  = 1'b0;
        in_if.data   = 8'h00;
        out_if.ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", 32'(out_if.valid), 32'd0);
        check_eq("rst_data", 32'(out_if.data), 32'd0);
        check_eq("rst_partial", 32'(out_partial), 32'd0);
        check_eq("rst_fill", 32'(fill), 32'd0);
        reset = 1'b1;

        // Full group, one-cycle latency
        expect_word(24'h332211, 1'b0);
        push(8'h11);
        check_eq("fill_1", 32'(fill), 32'd1);
        push(8'h22);
        push(8'h33);
        check_eq("lat_valid", 32'(out_if.valid), 32'd1);
        check_eq("lat_data", 32'(out_if.data), 32'h332211);
        check_eq("lat_partial", 32'(out_partial), 32'd0);
        check_eq("lat_fill", 32'(fill), 32'd0);
        idle();
        check_eq("drain_valid", 32'(out_if.valid), 32'd0);
        check_eq("drain_hold_data", 32'(out_if.data), 32'h332211);

        // Partial flush then lane 0 restart
        expect_word(24'h00BBAA, 1'b1);
        expect_word(24'hEEDDCC, 1'b0);
        push(8'hAA);
        push(8'hBB);
        check_eq("fill_2", 32'(fill), 32'd2);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        check_eq("flush_data", 32'(out_if.data), 32'h00BBAA);
        check_eq("flush_partial", 32'(out_partial), 32'd1);
        check_eq("flush_fill", 32'(fill), 32'd0);
        push(8'hCC);
        push(8'hDD);
        push(8'hEE);
        idle();

        // Flush with empty accumulator is ignored
        step(1'b0, 8'h00, 1'b1, 1'b1);
        check_eq("flush_empty_valid", 32'(out_if.valid), 32'd0);

        // Flush with completing word, then with non-completing word
        expect_word(24'h030201, 1'b0);
        expect_word(24'h000504, 1'b1);
        push(8'h01);
        push(8'h02);
        step(1'b1, 8'h03, 1'b1, 1'b1);
        check_eq("flush_full_partial", 32'(out_partial), 32'd0);
        push(8'h04);
        step(1'b1, 8'h05, 1'b1, 1'b1);
        check_eq("flush_inc_partial", 32'(out_partial), 32'd1);
        check_eq("flush_inc_fill", 32'(fill), 32'd0);
        idle();

        // Sustained streaming
        expect_word(24'h030201, 1'b0);
        expect_word(24'h060504, 1'b0);
        expect_word(24'h090807, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            push(8'(i));
            check_eq("stream_ready", 32'(rdy_s), 32'd1);
        end
        idle();

        // Backpressure: stall with flush asserted, then release
        expect_word(24'h232221, 1'b0);
        expect_word(24'h333231, 1'b0);
        push(8'h21);
        push(8'h22);
        step(1'b1, 8'h23, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h31, 1'b1, 1'b0);
            check_eq("stall_ready", 32'(rdy_s), 32'd0);
            check_eq("stall_data", 32'(odata_s), 32'h232221);
            check_eq("stall_fill", 32'(fill), 32'd0);
        end
        step(1'b1, 8'h31, 1'b0, 1'b1);
        check_eq("release_ready", 32'(rdy_s), 32'd1);
        check_eq("release_fill", 32'(fill), 32'd1);
        push(8'h32);
        push(8'h33);
        idle();

        // Reset mid-group discards held words
        expect_word(24'h665544, 1'b0);
        push(8'h11);
        push(8'h22);
        reset = 1'b0;
        idle();
        reset = 1'b1;
        check_eq("midrst_fill", 32'(fill), 32'd0);
        check_eq("midrst_valid", 32'(out_if.valid), 32'd0);
        push(8'h44);
        push(8'h55);
        push(8'h66);
        idle();
        idle();

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
